// File: rtl/sata_tx_align_inserter.sv
// sata_tx_align_inserter
// TX stage between the OOB controller and the PHY transmitter.
//
// While the link is down, the OOB controller's dword and K flag pass straight
// through. Once linkup is high, the stage forwards link-layer dwords. Every
// ALIGN_INTERVAL dwords it inserts a burst of ALIGN_BURST ALIGN primitives.
// During that burst, link_tx_ready holds the link layer off.
//
// Optional build macro: ALIGN_STATS_EN
//   This macro adds the align_pair_cnt output. It counts completed ALIGN bursts.
//   Only rst clears it.

`ifndef PRIM_ALIGN
`define PRIM_ALIGN 32'h7B4A_4ABC
`endif

module sata_tx_align_inserter #(
  parameter int ALIGN_INTERVAL = 256,  // dwords per period, ALIGN burst included
  parameter int ALIGN_BURST    = 2     // consecutive ALIGNs at the head of a period
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        linkup,
  input  logic [31:0] oob_tx_dout,
  input  logic        oob_tx_isk,
  input  logic [31:0] link_tx_dout,
  input  logic        link_tx_isk,
  output logic        link_tx_ready,
  output logic [31:0] phy_tx_dout,
  output logic        phy_tx_isk
`ifdef ALIGN_STATS_EN
  ,
  output logic [31:0] align_pair_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_OOB   = 2'd0,
    ST_ALIGN = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  // A single counter is enough. It counts burst cycles in ST_ALIGN and
  // accepted dwords in ST_DATA. It is cleared on every state change.
  localparam logic [15:0] BURST_LAST = 16'(ALIGN_BURST - 1);
  localparam logic [15:0] DATA_LAST  = 16'(ALIGN_INTERVAL - ALIGN_BURST - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [31:0] phy_dout_q;
  logic        phy_isk_q;
  logic        ready_q;

  // FSM. The PHY output register and the ready flag are updated together, so
  // every output comes straight from a flop.
  // NOTE: sequential state uses non-blocking (<=) assignments only. Every flop
  // then samples its pre-edge value, whatever the order of the statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OOB;
      cnt_q      <= '0;
      phy_dout_q <= '0;
      phy_isk_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else if (!linkup) begin
      // Losing the link abandons any partial burst or period.
      // The OOB dword goes out on this same edge.
      state_q    <= ST_OOB;
      cnt_q      <= '0;
      phy_dout_q <= oob_tx_dout;
      phy_isk_q  <= oob_tx_isk;
      ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_OOB: begin
          phy_dout_q <= oob_tx_dout;
          phy_isk_q  <= oob_tx_isk;
          state_q    <= ST_ALIGN;
          cnt_q      <= '0;
          ready_q    <= 1'b0;
        end
        ST_ALIGN: begin
          phy_dout_q <= `PRIM_ALIGN;
          phy_isk_q  <= 1'b1;
          if (cnt_q == BURST_LAST) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
            ready_q <= 1'b0;
          end
        end
        ST_DATA: begin
          // ready_q is high for this whole state, so the link dword is
          // consumed on every cycle spent here.
          phy_dout_q <= link_tx_dout;
          phy_isk_q  <= link_tx_isk;
          if (cnt_q == DATA_LAST) begin
            state_q <= ST_ALIGN;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_OOB;
          cnt_q      <= '0;
          phy_dout_q <= oob_tx_dout;
          phy_isk_q  <= oob_tx_isk;
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALIGN_STATS_EN
  logic [31:0] pair_cnt_q;

  // Counts each completed burst (ALIGN -> DATA). Wraps modulo 2^32.
  // A linkup drop does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt_q <= '0;
    end else if (linkup && state_q == ST_ALIGN && cnt_q == BURST_LAST) begin
      pair_cnt_q <= pair_cnt_q + 32'd1;
    end
  end

  assign align_pair_cnt = pair_cnt_q;
`endif

  assign link_tx_ready = ready_q;
  assign phy_tx_dout   = phy_dout_q;
  assign phy_tx_isk    = phy_isk_q;

endmodule

// File: tb/tb_sata_tx_align_inserter.sv
// Testbench for sata_tx_align_inserter (ALIGN_INTERVAL=256, ALIGN_BURST=2).
// The behavioural model places every clock edge inside the period using only
// "edges since linkup was first seen high". A negedge process compares the DUT
// against the model. The directed sequence adds hand-computed literal checks.

`ifndef PRIM_ALIGN
`define PRIM_ALIGN 32'h7B4A_4ABC
`endif

module tb_sata_tx_align_inserter;

  localparam int INTERVAL = 256;
  localparam int BURST    = 2;
  localparam int NWORDS   = 4096;
  localparam logic [31:0] ALIGN_W = `PRIM_ALIGN;

  logic        clk = 1'b0;
  logic        rst;
  logic        linkup;
  logic [31:0] oob_tx_dout;
  logic        oob_tx_isk;
  logic [31:0] link_tx_dout;
  logic        link_tx_isk;
  logic        link_tx_ready;
  logic [31:0] phy_tx_dout;
  logic        phy_tx_isk;
`ifdef ALIGN_STATS_EN
  logic [31:0] align_pair_cnt;
`endif

  always #5 clk = ~clk;

  sata_tx_align_inserter #(
    .ALIGN_INTERVAL(INTERVAL),
    .ALIGN_BURST   (BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .linkup       (linkup),
    .oob_tx_dout  (oob_tx_dout),
    .oob_tx_isk   (oob_tx_isk),
    .link_tx_dout (link_tx_dout),
    .link_tx_isk  (link_tx_isk),
    .link_tx_ready(link_tx_ready),
    .phy_tx_dout  (phy_tx_dout),
    .phy_tx_isk   (phy_tx_isk)
`ifdef ALIGN_STATS_EN
    ,
    .align_pair_cnt(align_pair_cnt)
`endif
  );

  // Link-layer source: a fixed table of dwords. The driver advances it only
  // after an edge at which ready was high.
  logic [31:0] words    [NWORDS];
  logic        word_isk [NWORDS];
  int          lidx;

  assign link_tx_dout = words[lidx];
  assign link_tx_isk  = word_isk[lidx];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge. Inputs change 1 time unit after the edge.
  task automatic tick();
    logic ready_pre;
    ready_pre = link_tx_ready;
    @(posedge clk);
    #1;
    if (ready_pre === 1'b1 && lidx < NWORDS - 1) lidx++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   The model counts edges since linkup was first seen high (k).
  //   k == 0                : the OOB dword is still forwarded.
  //   m = (k-1) % INTERVAL  : position in the period.
  //   m <  BURST            : an ALIGN is inserted.
  //   m >= BURST            : the next unconsumed table word is forwarded.
  //   After that edge, ready is high iff k % INTERVAL >= BURST.
  // ---------------------------------------------------------------------------
  bit          exp_valid = 0;
  logic [31:0] exp_dout;
  logic        exp_isk;
  logic        exp_ready;
  bit          up = 0;
  int          k = 0;
  int          midx = 0;
  int unsigned exp_pairs = 0;

  always @(negedge clk) begin
    int m;
    if (exp_valid) begin
      check("phy_tx_dout", phy_tx_dout, exp_dout);
      check("phy_tx_isk", {31'd0, phy_tx_isk}, {31'd0, exp_isk});
      check("link_tx_ready", {31'd0, link_tx_ready}, {31'd0, exp_ready});
`ifdef ALIGN_STATS_EN
      check("align_pair_cnt", align_pair_cnt, exp_pairs);
`endif
    end
    // Predict the outputs for the coming edge from the inputs now stable.
    if (rst) begin
      exp_dout  = '0;
      exp_isk   = 1'b0;
      exp_ready = 1'b0;
      up        = 0;
      exp_pairs = 0;
    end else if (!linkup) begin
      exp_dout  = oob_tx_dout;
      exp_isk   = oob_tx_isk;
      exp_ready = 1'b0;
      up        = 0;
    end else begin
      if (!up) begin
        up = 1;
        k  = 0;
      end else begin
        k++;
      end
      if (k == 0) begin
        exp_dout = oob_tx_dout;
        exp_isk  = oob_tx_isk;
      end else begin
        m = (k - 1) % INTERVAL;
        if (m < BURST) begin
          exp_dout = ALIGN_W;
          exp_isk  = 1'b1;
          if (m == BURST - 1) exp_pairs++;
        end else begin
          exp_dout = words[midx];
          exp_isk  = word_isk[midx];
          midx++;
        end
      end
      exp_ready = ((k % INTERVAL) >= BURST);
    end
    exp_valid = 1;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. In the comments, T is the first edge at which linkup is
  // sampled high.
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      words[i]    = 32'(i);
      word_isk[i] = 1'b0;
    end
    // The link layer sends two ALIGNs of its own. They are plain data.
    words[300] = ALIGN_W;  word_isk[300] = 1'b1;
    words[301] = ALIGN_W;  word_isk[301] = 1'b1;

    lidx        = 0;
    rst         = 1'b1;
    linkup      = 1'b0;
    oob_tx_dout = 32'h4A4A_4A4A;
    oob_tx_isk  = 1'b0;

    // Reset and OOB passthrough.
    repeat (4) begin
      tick();
      check("reset_phy", phy_tx_dout, 32'h0);
      check("reset_ready", {31'd0, link_tx_ready}, 32'd0);
    end
    rst = 1'b0;
    tick();
    check("oob_pass", phy_tx_dout, 32'h4A4A_4A4A);
    check("oob_ready", {31'd0, link_tx_ready}, 32'd0);
    tick();

    // Linkup rises. The first burst follows.
    linkup = 1'b1;
    tick();  // T
    check("T_oob", phy_tx_dout, 32'h4A4A_4A4A);
    tick();  // T+1
    check("T1_align", phy_tx_dout, ALIGN_W);
    check("T1_isk", {31'd0, phy_tx_isk}, 32'd1);
    check("T1_ready", {31'd0, link_tx_ready}, 32'd0);
    tick();  // T+2
    check("T2_align", phy_tx_dout, ALIGN_W);
    check("T2_ready", {31'd0, link_tx_ready}, 32'd1);
    tick();  // T+3
    check("T3_data0", phy_tx_dout, 32'd0);
    check("T3_isk", {31'd0, phy_tx_isk}, 32'd0);

    // The 254-dword data window and the next burst.
    ticks(253);  // T+256
    check("data253", phy_tx_dout, 32'd253);
    tick();      // T+257
    check("p1_align0", phy_tx_dout, ALIGN_W);
    tick();      // T+258
    check("p1_align1", phy_tx_dout, ALIGN_W);
    tick();      // T+259
    check("data254", phy_tx_dout, 32'd254);

    // The link-supplied ALIGNs are forwarded in order and do not move the period.
    ticks(46);   // T+305
    check("link_align300", phy_tx_dout, ALIGN_W);
    check("link_align300_isk", {31'd0, phy_tx_isk}, 32'd1);
    tick();      // T+306
    check("link_align301", phy_tx_dout, ALIGN_W);
    ticks(207);  // T+513
    check("p2_align0", phy_tx_dout, ALIGN_W);
    tick();      // T+514
`ifdef ALIGN_STATS_EN
    check("pairs_after_3", align_pair_cnt, 32'd3);
`endif
    tick();      // T+515
    check("data508", phy_tx_dout, 32'd508);

    // Run to ten full periods, then drop linkup after the first ALIGN.
    ticks(2045);  // T+2560
    check("data2539", phy_tx_dout, 32'd2539);
    tick();       // T+2561
    check("p10_align0", phy_tx_dout, ALIGN_W);
    linkup      = 1'b0;
    oob_tx_dout = 32'hB5B5_B5B5;
    oob_tx_isk  = 1'b1;
    tick();       // T+2562
    check("drop_oob", phy_tx_dout, 32'hB5B5_B5B5);
    check("drop_ready", {31'd0, link_tx_ready}, 32'd0);
`ifdef ALIGN_STATS_EN
    check("pairs_after_10", align_pair_cnt, 32'd10);
`endif
    ticks(2);

    // Raise linkup again. A full two-ALIGN burst comes first.
    linkup = 1'b1;
    tick();  // U
    check("U_oob", phy_tx_dout, 32'hB5B5_B5B5);
    tick();  // U+1
    check("U1_align", phy_tx_dout, ALIGN_W);
    tick();  // U+2
    check("U2_align", phy_tx_dout, ALIGN_W);
    tick();  // U+3
    check("U3_data2540", phy_tx_dout, 32'd2540);
    ticks(300);
`ifdef ALIGN_STATS_EN
    check("pairs_after_12", align_pair_cnt, 32'd12);
`endif

    // Reset in the middle of a data window.
    rst    = 1'b1;
    linkup = 1'b0;
    tick();
    check("rst_mid_phy", phy_tx_dout, 32'h0);
    check("rst_mid_ready", {31'd0, link_tx_ready}, 32'd0);
`ifdef ALIGN_STATS_EN
    check("rst_pairs", align_pair_cnt, 32'd0);
`endif
    rst = 1'b0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
